seq_mul_unit: RTL and testbench
===============================

Name: seq_mul_unit

Overview:
Multi-cycle multiplier in the KGPMini execute path, directly downstream of the register file.
- Consumes the two read ports (data1/data2) as operands.
- Computes a 2×WIDTH product by radix-2 shift-add.
- Drives the register-file write port (writeData/writeReg/RegWrite) with the low word; the high word is held in an internal HI register.
- The control unit stalls on busy.

Parameters:
WIDTH, 32, operand width (matches regfile data width)
REG_ADDR_W, 5, register index width (32 architectural registers)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
opA  input  WIDTH  multiplicand (regfile data1)
opB  input  WIDTH  multiplier (regfile data2)
destReg  input  REG_ADDR_W  destination register for low word
isSigned  input  1  signed-multiply request (honoured only with MUL_SIGNED_EN)
busy  output  1  high from the cycle after start is accepted until the writeback cycle ends
done  output  1  one-cycle pulse, coincident with RegWrite
writeData  output  WIDTH  low word of product to regfile
writeReg  output  REG_ADDR_W  latched destReg
RegWrite  output  1  regfile write enable, one-cycle pulse
hi  output  WIDTH  high word of last completed product

Behaviour:
Reset (reset=0, async):
- State → IDLE.
- busy, done, RegWrite = 0; writeData, writeReg, hi = 0.
- Accumulator, counter and latched operands = 0.

States: IDLE, BUSY, WB.
- IDLE, start=1:
  - Latch opA, opB, destReg (and sign info).
  - Clear 2×WIDTH accumulator; counter = WIDTH.
  - Go to BUSY.
- BUSY, each cycle:
  - If multiplier LSB=1, add multiplicand to upper half of accumulator (WIDTH+1-bit add, carry kept).
  - Shift accumulator right by 1; decrement counter.
  - When counter reaches 0 → WB.
- WB, single cycle:
  - RegWrite=1, done=1, writeData=acc[WIDTH-1:0], writeReg=latched destReg.
  - hi updated with acc[2W-1:W].
  - Next cycle → IDLE.

Latency:
- start sampled at edge 0; RegWrite high during cycle WIDTH+1 (33 at default).
- Fixed latency: no early termination on zero operands.

Handshake:
- start ignored in BUSY and WB; no queueing.
- start in the IDLE cycle immediately following WB is accepted (back-to-back throughput WIDTH+2 cycles).
- Operands need be valid only in the accept cycle; later changes on opA/opB/destReg have no effect.

Boundaries:
- Operands 0 → product 0, still full latency and a write.
- destReg=0 is written like any other register; no special-casing.
- All-ones unsigned operands must not overflow the accumulator (carry bit retained).

Reset mid-operation:
- Immediate abort; no RegWrite.
- hi retains its reset value 0, not a partial product.

Optional Feature:
MUL_SIGNED_EN
- Defined:
  - isSigned=1 latches operand signs and multiplies magnitudes.
  - At WB the 2×WIDTH result is two's-complement negated if signs differ.
  - Same latency.
  - Most-negative operand handled: magnitude 2^(W-1) fits the unsigned datapath.
- Undefined: isSigned is ignored (treated as 0); all multiplies unsigned; port remains present.

Decomposition:
- Package kgp_mul_pkg:
  - state enum (IDLE/BUSY/WB);
  - WIDTH/REG_ADDR_W defaults;
  - counter width constant CNT_W = clog2(WIDTH)+1.
- One natural sub-module: shift_add_core.
  - Holds the accumulator, multiplicand, counter and add/shift step.
  - Reports last_step to the FSM in the top level.
- Top level holds the FSM, operand/dest latching, sign handling and output registers.

Test Plan:
- Reset release, start with opA=7, opB=6, destReg=3:
  - busy=1 cycles 1–32;
  - cycle 33: RegWrite=1, done=1, writeReg=3, writeData=42;
  - hi=0 afterwards.
- Unsigned opA=opB=0xFFFFFFFF → writeData=0x00000001, hi=0xFFFFFFFE.
- start pulsed again at cycle 10 with different operands → ignored; single writeback of the original product at cycle 33; busy never drops early.
- reset asserted at cycle 15 of an operation → busy=0 immediately, no RegWrite ever issued, hi=0; a subsequent start 5×5 completes with writeData=25.
- Back-to-back: second start in the IDLE cycle right after WB → accepted; second RegWrite exactly 34 cycles after the first.
- With MUL_SIGNED_EN, isSigned=1, opA=-3, opB=5 → writeData=0xFFFFFFF1, hi=0xFFFFFFFF.
- Without MUL_SIGNED_EN, same stimulus → unsigned result: writeData=0xFFFFFFF1, hi=0x00000004.

Source files
------------

// File: rtl/kgp_mul_pkg.sv
// Shared types and sizing for the KGPMini shift-add multiplier.
package kgp_mul_pkg;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_REG_ADDR_W = 5;

  typedef enum logic [1:0] {StIdle, StBusy, StWb} mulState_e;

  // Counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int unsigned cntWidth(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

  localparam int unsigned CNT_W = cntWidth(DEF_WIDTH);

endpackage

// File: rtl/shift_add_core.sv
// Radix-2 shift-add datapath: accumulator, multiplicand, step counter.
module shift_add_core
  import kgp_mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               run,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] accNext,
  output logic               lastStep
);

  localparam int unsigned CntW = cntWidth(WIDTH);

  logic [2*WIDTH-1:0] accQ;
  logic [WIDTH-1:0]   mcandQ;
  logic [CntW-1:0]    cntQ;
  logic [WIDTH:0]     sum;

  // The multiplier rides in the low half and is consumed as the product shifts in.
  always_comb begin
    sum      = {1'b0, accQ[2*WIDTH-1:WIDTH]} + (accQ[0] ? {1'b0, mcandQ} : '0);
    accNext  = {sum, accQ[WIDTH-1:1]};
    lastStep = run && (cntQ == CntW'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accQ   <= '0;
      mcandQ <= '0;
      cntQ   <= '0;
    end else if (load) begin
      accQ   <= {{WIDTH{1'b0}}, mplier};
      mcandQ <= mcand;
      cntQ   <= CntW'(WIDTH);
    end else if (run) begin
      accQ   <= accNext;
      cntQ   <= cntQ - CntW'(1);
    end
  end

endmodule

// File: rtl/seq_mul_unit.sv
// Multi-cycle multiplier feeding the regfile write port; HI kept internally.
// Optional signed support is enabled by defining MUL_SIGNED_EN.
module seq_mul_unit
  import kgp_mul_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      opA,
  input  logic [WIDTH-1:0]      opB,
  input  logic [REG_ADDR_W-1:0] destReg,
  input  logic                  isSigned,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      writeData,
  output logic [REG_ADDR_W-1:0] writeReg,
  output logic                  RegWrite,
  output logic [WIDTH-1:0]      hi
);

  mulState_e             stateQ;
  logic [REG_ADDR_W-1:0] destRegQ;
  logic                  negQ;
  logic                  negNext;
  logic [WIDTH-1:0]      mcandIn;
  logic [WIDTH-1:0]      mplierIn;
  logic [2*WIDTH-1:0]    accNext;
  logic [2*WIDTH-1:0]    result;
  logic                  lastStep;
  logic                  load;
  logic                  run;

  assign load = (stateQ == StIdle) && start;
  assign run  = (stateQ == StBusy);

`ifdef MUL_SIGNED_EN
  logic negA;
  logic negB;

  // Magnitude of the most-negative value is 2^(W-1), still representable unsigned.
  always_comb begin
    negA     = isSigned & opA[WIDTH-1];
    negB     = isSigned & opB[WIDTH-1];
    mcandIn  = negA ? (~opA + 1'b1) : opA;
    mplierIn = negB ? (~opB + 1'b1) : opB;
    negNext  = negA ^ negB;
    result   = negQ ? (~accNext + 1'b1) : accNext;
  end
`else
  logic unusedIsSigned;

  always_comb begin
    unusedIsSigned = isSigned;
    mcandIn        = opA;
    mplierIn       = opB;
    negNext        = 1'b0;
    result         = accNext;
  end
`endif

  shift_add_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .run     (run),
    .mcand   (mcandIn),
    .mplier  (mplierIn),
    .accNext (accNext),
    .lastStep(lastStep)
  );

  // Outputs are loaded on the final step edge so the WB cycle presents them directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ    <= StIdle;
      destRegQ  <= '0;
      negQ      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      RegWrite  <= 1'b0;
      writeData <= '0;
      writeReg  <= '0;
      hi        <= '0;
    end else begin
      case (stateQ)
        StIdle: begin
          if (start) begin
            stateQ   <= StBusy;
            busy     <= 1'b1;
            destRegQ <= destReg;
            negQ     <= negNext;
          end
        end
        StBusy: begin
          if (lastStep) begin
            stateQ    <= StWb;
            RegWrite  <= 1'b1;
            done      <= 1'b1;
            writeData <= result[WIDTH-1:0];
            hi        <= result[2*WIDTH-1:WIDTH];
            writeReg  <= destRegQ;
          end
        end
        StWb: begin
          stateQ   <= StIdle;
          busy     <= 1'b0;
          RegWrite <= 1'b0;
          done     <= 1'b0;
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_unit.sv
// Self-checking bench for seq_mul_unit: transaction-level model plus directed pins.
module tb_seq_mul_unit;

  localparam int W   = 32;
  localparam int RW  = 5;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          isSigned = 1'b0;
  logic [W-1:0]  opA = '0;
  logic [W-1:0]  opB = '0;
  logic [RW-1:0] destReg = '0;
  logic          busy;
  logic          done;
  logic          RegWrite;
  logic [W-1:0]  writeData;
  logic [W-1:0]  hi;
  logic [RW-1:0] writeReg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  seq_mul_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .opA      (opA),
    .opB      (opB),
    .destReg  (destReg),
    .isSigned (isSigned),
    .busy     (busy),
    .done     (done),
    .writeData(writeData),
    .writeReg (writeReg),
    .RegWrite (RegWrite),
    .hi       (hi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] refProd(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
`ifdef MUL_SIGNED_EN
    if (s) return $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
`endif
    return {32'b0, a} * {32'b0, b} + 64'(s & 1'b0);
  endfunction

  // Transaction model: an accepted request occupies LAT cycles, the last being writeback.
  bit            mActive = 0;
  int            mCnt = 0;
  logic [63:0]   mProd = '0;
  logic [RW-1:0] mDest = '0;
  logic [RW-1:0] mLastReg = '0;
  logic [W-1:0]  mLastLo = '0;
  logic [W-1:0]  mHi = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mActive  <= 0;
      mCnt     <= 0;
      mLastReg <= '0;
      mLastLo  <= '0;
      mHi      <= '0;
    end else if (!mActive) begin
      if (start) begin
        mActive <= 1;
        mCnt    <= 1;
        mProd   <= refProd(opA, opB, isSigned);
        mDest   <= destReg;
      end
    end else if (mCnt == LAT) begin
      mActive  <= 0;
      mCnt     <= 0;
      mLastLo  <= mProd[31:0];
      mHi      <= mProd[63:32];
      mLastReg <= mDest;
    end else begin
      mCnt <= mCnt + 1;
    end
  end

  always @(negedge clk) begin
    logic wb;
    wb = mActive && (mCnt == LAT);
    check("busy", busy, mActive);
    check("RegWrite", RegWrite, wb);
    check("done", done, wb);
    check("writeData", writeData, wb ? mProd[31:0] : mLastLo);
    check("writeReg", writeReg, wb ? mDest : mLastReg);
    check("hi", hi, wb ? mProd[63:32] : mHi);
  end

  task automatic doStart(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [RW-1:0] d, input logic s);
    @(posedge clk);
    #2;
    start = 1'b1; opA = a; opB = b; destReg = d; isSigned = s;
    @(posedge clk);
    #2;
    start = 1'b0; opA = $urandom; opB = $urandom; destReg = RW'($urandom);
  endtask

  task automatic waitWb(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (RegWrite) return;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int first;
    int second;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    doStart(32'd7, 32'd6, 5'd3, 1'b0);
    waitWb(n);
    check("t1Latency", n, LAT);
    check("t1Data", writeData, 64'd42);
    check("t1Reg", writeReg, 64'd3);
    check("t1Done", done, 64'd1);
    @(negedge clk);
    check("t1Hi", hi, 64'd0);

    doStart(32'd100, 32'd200, 5'd7, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    start = 1'b1; opA = 32'd11; opB = 32'd13; destReg = 5'd9;
    @(posedge clk);
    #2 start = 1'b0;
    waitWb(n);
    check("ignoreLatency", n, LAT - 10);
    check("ignoreData", writeData, 64'd20000);
    check("ignoreReg", writeReg, 64'd7);

    doStart(32'd12, 32'd12, 5'd4, 1'b0);
    waitWb(n);
    first = cyc;
    check("b2bFirst", writeData, 64'd144);
    start = 1'b1; opA = 32'd3; opB = 32'd9; destReg = 5'd5;
    @(posedge clk);
    @(posedge clk);
    #2 start = 1'b0;
    waitWb(n);
    second = cyc;
    check("b2bGap", second - first, W + 2);
    check("b2bSecond", writeData, 64'd27);

    doStart(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b0);
    waitWb(n);
    check("onesData", writeData, 64'h0000_0001);
    check("onesHi", hi, 64'hFFFF_FFFE);

    doStart(32'hDEAD_BEEF, 32'h1234_5678, 5'd6, 1'b0);
    repeat (14) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rstBusy", busy, 64'd0);
    check("rstRegWrite", RegWrite, 64'd0);
    check("rstHi", hi, 64'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    doStart(32'd5, 32'd5, 5'd2, 1'b0);
    waitWb(n);
    check("postRstLatency", n, LAT);
    check("postRstData", writeData, 64'd25);

    doStart(32'hFFFF_FFFD, 32'd5, 5'd1, 1'b1);
    waitWb(n);
    check("negData", writeData, 64'hFFFF_FFF1);
`ifdef MUL_SIGNED_EN
    check("negHi", hi, 64'hFFFF_FFFF);
`else
    check("negHi", hi, 64'h0000_0004);
`endif

    doStart(32'd0, 32'd12345, 5'd0, 1'b0);
    waitWb(n);
    check("zeroLatency", n, LAT);
    check("zeroData", writeData, 64'd0);
    check("zeroReg", writeReg, 64'd0);

    repeat (600) begin
      @(posedge clk);
      #2;
      start    = ($urandom_range(0, 3) == 0);
      opA      = pick();
      opB      = pick();
      destReg  = RW'($urandom);
      isSigned = 1'($urandom);
    end
    #0 start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
